spi_reg_responder: RTL and testbench

SPI responder that puts an 8-bit register bank on the serial bus driven by the team's SPI master, configured for 16-bit frames.
- Each CS-low frame is one 8-bit command byte, `{wr, addr[6:0]}`, then one 8-bit data byte, MSB first, SPI mode 0.
- Read data goes out on MISO during the data byte.
- Writes commit into the bank when CS deasserts.
- A host-side port gives local logic direct read/write access to the same bank.

---
 rtl/spi_reg_responder_if.sv | 29 ++
 rtl/spi_reg_responder.sv | 153 +++++++++++++++
 tb/tb_spi_reg_responder.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_reg_responder_if.sv
// Host-side bus of spi_reg_responder: direct register access plus the
// completed-access report stream.
//   host_addr/host_we/host_wdata : local write port (master drives)
//   host_rdata                   : combinational read of reg[host_addr]
//   acc_valid/acc_wr/acc_addr/acc_data : one-cycle report of an SPI access
//   frame_err                    : one-cycle pulse on a malformed frame
interface spi_reg_responder_if #(
  parameter int unsigned AW = 4
);
  logic [AW-1:0] host_addr;
  logic [7:0]    host_rdata;
  logic          host_we;
  logic [7:0]    host_wdata;
  logic          acc_valid;
  logic          acc_wr;
  logic [6:0]    acc_addr;
  logic [7:0]    acc_data;
  logic          frame_err;

  modport master (
    output host_addr, host_we, host_wdata,
    input  host_rdata, acc_valid, acc_wr, acc_addr, acc_data, frame_err
  );

  modport slave (
    input  host_addr, host_we, host_wdata,
    output host_rdata, acc_valid, acc_wr, acc_addr, acc_data, frame_err
  );
endinterface

// File: rtl/spi_reg_responder.sv
// SPI mode-0 responder exposing an 8-bit register bank. A frame is a command
// byte {wr, addr[6:0]} followed by a data byte, MSB first. Writes commit when
// CS deasserts; read data is shifted out on MISO during the data byte.
// Ports:
//   Clock, Reset        : system clock, async active-low reset
//   SCLK, CS, MOSI      : serial inputs, asynchronous to Clock
//   MISO                : serial output, tri-stated unless selected
//   bus (slave modport) : host register port and access reporting
module spi_reg_responder #(
  parameter int unsigned NREG = 16,
  parameter int unsigned AW   = $clog2(NREG)
) (
  input  logic Clock,
  input  logic Reset,
  input  logic SCLK,
  input  logic CS,
  input  logic MOSI,
  inout  wire  MISO,
  spi_reg_responder_if.slave bus
);

  typedef enum logic [1:0] {S_WAIT, S_IDLE, S_CMD, S_DATA} state_t;

  state_t     state;
  logic       sclk_m, sclk_s, sclk_d;
  logic       cs_m, cs_s;
  logic       mosi_m, mosi_s;
  logic       rise, fall;
  logic [1:0] settle;
  logic [4:0] bit_cnt;
  logic [7:0] rx, tx, cmd, rd_val;
  logic [7:0] rd_next;
  logic       addr_hit, host_hit, spi_commit;
  logic       end_pend, end_ok;
  logic       acc_valid, acc_wr, frame_err;
  logic [6:0] acc_addr;
  logic [7:0] acc_data;
  logic [7:0] bank [NREG];

  // Two-flop synchronizers plus a third SCLK flop for edge detection
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      sclk_m <= 1'b0; sclk_s <= 1'b0; sclk_d <= 1'b0;
      cs_m   <= 1'b1; cs_s   <= 1'b1;
      mosi_m <= 1'b0; mosi_s <= 1'b0;
    end else begin
      sclk_m <= SCLK; sclk_s <= sclk_m; sclk_d <= sclk_s;
      cs_m   <= CS;   cs_s   <= cs_m;
      mosi_m <= MOSI; mosi_s <= mosi_m;
    end
  end

  assign rise = sclk_s & ~sclk_d;
  assign fall = ~sclk_s & sclk_d;

  assign addr_hit   = 32'(cmd[6:0]) < NREG;
  assign host_hit   = 32'(bus.host_addr) < NREG;
  assign rd_next    = addr_hit ? bank[AW'(cmd[6:0])] : 8'h00;
  // Commit happens in the same cycle acc_valid is registered
  assign spi_commit = end_pend & end_ok & cmd[7] & addr_hit;

  // Frame FSM, shift registers and access reporting
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state     <= S_WAIT;
      settle    <= 2'd0;
      bit_cnt   <= 5'd0;
      rx        <= 8'h00;
      tx        <= 8'h00;
      cmd       <= 8'h00;
      rd_val    <= 8'h00;
      end_pend  <= 1'b0;
      end_ok    <= 1'b0;
      acc_valid <= 1'b0;
      acc_wr    <= 1'b0;
      acc_addr  <= 7'h00;
      acc_data  <= 8'h00;
      frame_err <= 1'b0;
    end else begin
      end_pend  <= 1'b0;
      acc_valid <= 1'b0;
      frame_err <= 1'b0;
      // Synchronizer outputs hold reset values, not pin values, for two cycles
      if (settle != 2'd2) settle <= settle + 2'd1;

      if (end_pend) begin
        acc_valid <= end_ok;
        frame_err <= ~end_ok;
        if (end_ok) begin
          acc_wr   <= cmd[7];
          acc_addr <= cmd[6:0];
          acc_data <= cmd[7] ? rx : rd_val;
        end
      end

      case (state)
        S_WAIT: if (settle == 2'd2 && cs_s) state <= S_IDLE;
        S_IDLE: begin
          if (!cs_s) begin
            state   <= S_CMD;
            bit_cnt <= 5'd0;
            rx      <= 8'h00;
            tx      <= 8'h00;
          end
        end
        S_CMD, S_DATA: begin
          if (cs_s) begin
            state    <= S_IDLE;
            end_pend <= 1'b1;
            end_ok   <= (bit_cnt == 5'd16);
            tx       <= 8'h00;
          end else begin
            if (rise) begin
              rx <= {rx[6:0], mosi_s};
              if (bit_cnt != 5'd31) bit_cnt <= bit_cnt + 5'd1;
              if (state == S_CMD && bit_cnt == 5'd7) cmd <= {rx[6:0], mosi_s};
            end
            if (fall) begin
              if (state == S_CMD && bit_cnt == 5'd8) begin
                state  <= S_DATA;
                tx     <= rd_next;
                rd_val <= rd_next;
              end else if (state == S_DATA) begin
                tx <= {tx[6:0], 1'b0};
              end
            end
          end
        end
        default: state <= S_WAIT;
      endcase
    end
  end

  // Register bank; an SPI commit overrides a same-cycle host write
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < int'(NREG); i++) bank[i] <= 8'h00;
    end else begin
      if (bus.host_we && host_hit) bank[bus.host_addr] <= bus.host_wdata;
      if (spi_commit) bank[AW'(cmd[6:0])] <= rx;
    end
  end

  assign MISO = (!cs_s && state != S_WAIT) ? tx[7] : 1'bz;

  assign bus.host_rdata = bank[bus.host_addr];
  assign bus.acc_valid  = acc_valid;
  assign bus.acc_wr     = acc_wr;
  assign bus.acc_addr   = acc_addr;
  assign bus.acc_data   = acc_data;
  assign bus.frame_err  = frame_err;

endmodule

// File: tb/tb_spi_reg_responder.sv
// Bench for spi_reg_responder: a behavioural SPI master drives frames, a
// scoreboard queue holds the expected access reports, and a monitor pops and
// compares them whenever acc_valid or frame_err pulses.
module tb_spi_reg_responder;

  localparam int HALF = 5;
  localparam int GAP  = 2;

  typedef struct packed {
    logic       err;
    logic       wr;
    logic [6:0] addr;
    logic [7:0] data;
  } exp_t;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  logic sclk  = 1'b0;
  logic cs    = 1'b1;
  logic mosi  = 1'b0;
  wire  miso;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  pullup (miso);

  spi_reg_responder_if #(.AW(4)) bus ();

  spi_reg_responder #(.NREG(16), .AW(4)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .SCLK  (sclk),
    .CS    (cs),
    .MOSI  (mosi),
    .MISO  (miso),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor: every report pulse must match the oldest expectation
  always @(negedge Clock) begin
    if (Reset && (bus.acc_valid || bus.frame_err)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: acc_valid=%b frame_err=%b with nothing expected",
                 bus.acc_valid, bus.frame_err);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({bus.frame_err, bus.acc_valid} !== {e.err, ~e.err}) begin
          errors++;
          $display("FAIL pulse_kind: frame_err,acc_valid=%b%b expected %b%b",
                   bus.frame_err, bus.acc_valid, e.err, ~e.err);
        end else if (!e.err) begin
          checks++;
          if ({bus.acc_wr, bus.acc_addr, bus.acc_data} !== {e.wr, e.addr, e.data}) begin
            errors++;
            $display("FAIL acc_fields: wr=%b addr=%h data=%h expected wr=%b addr=%h data=%h",
                     bus.acc_wr, bus.acc_addr, bus.acc_data, e.wr, e.addr, e.data);
          end
        end
      end
    end
  end

  // SPI master, mode 0. Returns received bits and report-pulse observations
  // around the 4th Clock cycle after CS rises.
  task automatic spi_frame(input logic [15:0] dout, input int nbits,
                           output logic [15:0] din, output int pre,
                           output logic pv, output logic pe, output int post);
    din = 16'h0000;
    @(negedge Clock);
    cs = 1'b0;
    mosi = dout[15];
    repeat (HALF) @(negedge Clock);
    for (int i = 0; i < nbits; i++) begin
      sclk = 1'b1;
      din = {din[14:0], miso};
      repeat (HALF) @(negedge Clock);
      sclk = 1'b0;
      if (i < 15) mosi = dout[14-i];
      repeat (HALF) @(negedge Clock);
    end
    cs = 1'b1;
    pre = 0;
    repeat (3) begin
      @(negedge Clock);
      pre += int'(bus.acc_valid | bus.frame_err);
    end
    @(negedge Clock);
    pv = bus.acc_valid;
    pe = bus.frame_err;
    @(negedge Clock);
    post = int'(bus.acc_valid | bus.frame_err);
    repeat (GAP) @(negedge Clock);
  endtask

  task automatic test_reset;
    bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = 8'h00;
    Reset = 1'b0;
    repeat (3) @(negedge Clock);
    checks++;
    if ({bus.acc_valid, bus.frame_err, bus.acc_wr, bus.acc_addr, bus.acc_data} !== 18'h0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b err=%b wr=%b addr=%h data=%h expected all 0",
               bus.acc_valid, bus.frame_err, bus.acc_wr, bus.acc_addr, bus.acc_data);
    end
    checks++;
    if (miso !== 1'b1) begin
      errors++;
      $display("FAIL reset_miso: miso=%b expected undriven (pulled 1)", miso);
    end
    Reset = 1'b1;
    repeat (5) @(negedge Clock);
    begin
      int bad = 0;
      for (int a = 0; a < 16; a++) begin
        bus.host_addr = 4'(a);
        #1;
        if (bus.host_rdata !== 8'h00) bad++;
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL reset_bank: %0d registers nonzero expected 0", bad);
      end
    end
  endtask

  task automatic test_idle_read;
    logic [15:0] din; int pre, post; logic pv, pe;
    int bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clock);
      if (miso !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idle_miso: driven %0d cycles with CS high expected 0", bad);
    end
    sb.push_back(exp_t'{err:1'b0, wr:1'b0, addr:7'h00, data:8'h00});
    spi_frame(16'h0000, 16, din, pre, pv, pe, post);
    checks++;
    if (din !== 16'h0000) begin
      errors++; $display("FAIL idle_read_data: dataO=%h expected 0000", din);
    end
    checks++;
    if (pre != 0 || pv !== 1'b1 || pe !== 1'b0 || post != 0) begin
      errors++;
      $display("FAIL idle_read_timing: pre=%0d v=%b e=%b post=%0d expected 0 1 0 0", pre, pv, pe, post);
    end
  endtask

  task automatic test_write_read;
    logic [15:0] din; int pre, post; logic pv, pe;
    sb.push_back(exp_t'{err:1'b0, wr:1'b1, addr:7'h0A, data:8'h5C});
    spi_frame(16'h8A5C, 16, din, pre, pv, pe, post);
    checks++;
    if (pre != 0 || pv !== 1'b1 || pe !== 1'b0 || post != 0) begin
      errors++;
      $display("FAIL write_timing: pre=%0d v=%b e=%b post=%0d expected 0 1 0 0", pre, pv, pe, post);
    end
    bus.host_addr = 4'd10; #1;
    checks++;
    if (bus.host_rdata !== 8'h5C) begin
      errors++; $display("FAIL write_reg10: reg=%h expected 5c", bus.host_rdata);
    end
    sb.push_back(exp_t'{err:1'b0, wr:1'b0, addr:7'h0A, data:8'h5C});
    spi_frame(16'h0A00, 16, din, pre, pv, pe, post);
    checks++;
    if (din !== 16'h005C) begin
      errors++; $display("FAIL read_reg10: dataO=%h expected 005c", din);
    end
  endtask

  task automatic test_unmapped;
    logic [15:0] din; int pre, post; logic pv, pe;
    sb.push_back(exp_t'{err:1'b0, wr:1'b1, addr:7'h40, data:8'hFF});
    spi_frame(16'hC0FF, 16, din, pre, pv, pe, post);
    bus.host_addr = 4'd0; #1;
    checks++;
    if (bus.host_rdata !== 8'h00) begin
      errors++; $display("FAIL unmapped_alias: reg0=%h expected 00", bus.host_rdata);
    end
    sb.push_back(exp_t'{err:1'b0, wr:1'b0, addr:7'h40, data:8'h00});
    spi_frame(16'h4000, 16, din, pre, pv, pe, post);
    checks++;
    if (din !== 16'h0000) begin
      errors++; $display("FAIL unmapped_read: dataO=%h expected 0000", din);
    end
  endtask

  task automatic test_short_frame;
    logic [15:0] din; int pre, post; logic pv, pe;
    sb.push_back(exp_t'{err:1'b1, wr:1'b0, addr:7'h00, data:8'h00});
    spi_frame(16'h8AFF, 9, din, pre, pv, pe, post);
    checks++;
    if (pre != 0 || pv !== 1'b0 || pe !== 1'b1 || post != 0) begin
      errors++;
      $display("FAIL short_timing: pre=%0d v=%b e=%b post=%0d expected 0 0 1 0", pre, pv, pe, post);
    end
    bus.host_addr = 4'd10; #1;
    checks++;
    if (bus.host_rdata !== 8'h5C) begin
      errors++; $display("FAIL short_nowrite: reg10=%h expected 5c", bus.host_rdata);
    end
  endtask

  task automatic test_host;
    logic [15:0] din; int pre, post; logic pv, pe;
    sb.push_back(exp_t'{err:1'b0, wr:1'b1, addr:7'h03, data:8'h22});
    fork
      spi_frame(16'h8322, 16, din, pre, pv, pe, post);
      begin
        @(posedge cs);
        repeat (3) @(negedge Clock);
        bus.host_addr = 4'd3; bus.host_wdata = 8'h11; bus.host_we = 1'b1;
        @(negedge Clock);
        bus.host_we = 1'b0;
      end
    join
    bus.host_addr = 4'd3; #1;
    checks++;
    if (bus.host_rdata !== 8'h22) begin
      errors++; $display("FAIL host_collision: reg3=%h expected 22", bus.host_rdata);
    end
    @(negedge Clock);
    bus.host_addr = 4'd4; bus.host_wdata = 8'h33; bus.host_we = 1'b1;
    @(negedge Clock);
    bus.host_we = 1'b0;
    checks++;
    if (bus.host_rdata !== 8'h33) begin
      errors++; $display("FAIL host_write: reg4=%h expected 33", bus.host_rdata);
    end
    sb.push_back(exp_t'{err:1'b0, wr:1'b0, addr:7'h04, data:8'h33});
    spi_frame(16'h0400, 16, din, pre, pv, pe, post);
    checks++;
    if (din !== 16'h0033) begin
      errors++; $display("FAIL host_spi_read: dataO=%h expected 0033", din);
    end
  endtask

  task automatic test_reset_midframe;
    logic [15:0] din; int pre, post; logic pv, pe;
    fork
      spi_frame(16'h8A77, 16, din, pre, pv, pe, post);
      begin
        @(negedge cs);
        repeat (HALF + 5 * 2 * HALF + 2) @(negedge Clock);
        Reset = 1'b0;
        repeat (2) @(negedge Clock);
        bus.host_addr = 4'd10; #1;
        checks++;
        if ({bus.acc_valid, bus.frame_err, bus.acc_wr, bus.acc_addr, bus.acc_data} !== 18'h0
            || bus.host_rdata !== 8'h00) begin
          errors++;
          $display("FAIL midreset_outputs: valid=%b err=%b wr=%b addr=%h data=%h reg10=%h expected all 0",
                   bus.acc_valid, bus.frame_err, bus.acc_wr, bus.acc_addr, bus.acc_data, bus.host_rdata);
        end
        checks++;
        if (miso !== 1'b1) begin
          errors++; $display("FAIL midreset_miso: miso=%b expected undriven (pulled 1)", miso);
        end
        Reset = 1'b1;
      end
    join
    checks++;
    if (pre != 0 || pv !== 1'b0 || pe !== 1'b0 || post != 0) begin
      errors++;
      $display("FAIL midreset_ignored: pre=%0d v=%b e=%b post=%0d expected no pulse", pre, pv, pe, post);
    end
    bus.host_addr = 4'd10; #1;
    checks++;
    if (bus.host_rdata !== 8'h00) begin
      errors++; $display("FAIL midreset_nowrite: reg10=%h expected 00", bus.host_rdata);
    end
    sb.push_back(exp_t'{err:1'b0, wr:1'b1, addr:7'h01, data:8'h01});
    spi_frame(16'h8101, 16, din, pre, pv, pe, post);
    checks++;
    if (pv !== 1'b1 || pe !== 1'b0) begin
      errors++; $display("FAIL midreset_next: v=%b e=%b expected 1 0", pv, pe);
    end
    bus.host_addr = 4'd1; #1;
    checks++;
    if (bus.host_rdata !== 8'h01) begin
      errors++; $display("FAIL midreset_reg1: reg1=%h expected 01", bus.host_rdata);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] din; int pre, post; logic pv, pe;
    sb.push_back(exp_t'{err:1'b0, wr:1'b1, addr:7'h07, data:8'hA5});
    spi_frame(16'h87A5, 16, din, pre, pv, pe, post);
    sb.push_back(exp_t'{err:1'b0, wr:1'b0, addr:7'h07, data:8'hA5});
    spi_frame(16'h0700, 16, din, pre, pv, pe, post);
    checks++;
    if (din !== 16'h00A5) begin
      errors++; $display("FAIL b2b_read: dataO=%h expected 00a5", din);
    end
    sb.push_back(exp_t'{err:1'b0, wr:1'b1, addr:7'h0F, data:8'h3C});
    spi_frame(16'h8F3C, 16, din, pre, pv, pe, post);
    bus.host_addr = 4'd15; #1;
    checks++;
    if (bus.host_rdata !== 8'h3C) begin
      errors++; $display("FAIL b2b_reg15: reg15=%h expected 3c", bus.host_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_idle_read();
    test_write_read();
    test_unmapped();
    test_short_frame();
    test_host();
    test_reset_midframe();
    test_back_to_back();
    repeat (10) @(negedge Clock);
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: %0d reports missing expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
